// File: rtl/nv_fifo_pkg.sv
//------------------------------------------------------------------------------
// nv_fifo_pkg : width helpers and DEPTH legality check for the flopram FIFO
// Rev 1.0
//------------------------------------------------------------------------------
`default_nettype none

`define NV_FIFO_POW2_CHECK(D) \
  if (((D) < 2) || (((D) & ((D) - 1)) != 0)) begin : g_depth_check \
    $error("nv fifo: DEPTH must be a power of 2 and at least 2"); \
  end

package nv_fifo_pkg;

  function automatic int clog2(input int n);
    int r;
    int v;
    r = 0;
    v = n - 1;
    while (v > 0) begin
      r++;
      v = v >> 1;
    end
    return r;
  endfunction

  function automatic int ptr_w(input int depth);
    return clog2(depth);
  endfunction

  // Counts must represent DEPTH itself, hence one extra bit.
  function automatic int cnt_w(input int depth);
    return clog2(depth) + 1;
  endfunction

endpackage

`default_nettype wire

// File: rtl/nv_nvdla_flopram_fifo_param_if.sv
//------------------------------------------------------------------------------
// nv_nvdla_flopram_fifo_param_if : producer/consumer handshake bundle
// Rev 1.0
//------------------------------------------------------------------------------
`default_nettype none

interface nv_nvdla_flopram_fifo_param_if #(
  parameter int WIDTH = 50,
  parameter int DEPTH = 4
);
  import nv_fifo_pkg::*;

  logic                      wr_req;
  logic                      wr_ready;
  logic [WIDTH-1:0]          wr_data;
  logic                      rd_req;
  logic                      rd_ready;
  logic [WIDTH-1:0]          rd_data;
  logic [cnt_w(DEPTH)-1:0]   wr_count;

  modport master (
    output wr_req, wr_data, rd_ready,
    input  wr_ready, rd_req, rd_data, wr_count
  );

  modport slave (
    input  wr_req, wr_data, rd_ready,
    output wr_ready, rd_req, rd_data, wr_count
  );

endinterface

`default_nettype wire

// File: rtl/nv_nvdla_flopram_rwa.sv
//------------------------------------------------------------------------------
// nv_nvdla_flopram_rwa : staged-write flop RAM with combinational read mux
// Rev 1.0
//------------------------------------------------------------------------------
`default_nettype none

module nv_nvdla_flopram_rwa #(
  parameter int WIDTH = 50,
  parameter int DEPTH = 4,
  parameter int AW    = 2
) (
  input  logic             clk,
  input  logic             reset_,
  input  logic             we,
  input  logic [AW-1:0]    wa,
  input  logic [WIDTH-1:0] di,
  input  logic [AW-1:0]    ra,
  output logic [WIDTH-1:0] dout,
  output logic             stage_vld
);

  logic [WIDTH-1:0] di_d;
  logic [AW-1:0]    wa_d;
  logic [WIDTH-1:0] ram [DEPTH];
  logic [DEPTH-1:0] ent_we;

  always_ff @(posedge clk or negedge reset_) begin
    if (!reset_) stage_vld <= 1'b0;
    else         stage_vld <= we;
  end

  // Payload and address staging carry no reset; stage_vld alone qualifies them.
  always_ff @(posedge clk) begin
    if (we) begin
      di_d <= di;
      wa_d <= wa;
    end
  end

  always_comb begin
    ent_we = '0;
    for (int i = 0; i < DEPTH; i++) ent_we[i] = stage_vld && (wa_d == AW'(i));
  end

  always_ff @(posedge clk) begin
    for (int i = 0; i < DEPTH; i++) begin
      if (ent_we[i]) ram[i] <= di_d;
    end
  end

  always_comb begin
    dout = '0;
    for (int i = 0; i < DEPTH; i++) begin
      if (ra == AW'(i)) dout = ram[i];
    end
  end

endmodule

`default_nettype wire

// File: rtl/nv_nvdla_flopram_fifo_param.sv
//------------------------------------------------------------------------------
// nv_nvdla_flopram_fifo_param : parametrised flop FIFO, valid/ready both sides
// Rev 1.0
//------------------------------------------------------------------------------
`default_nettype none

module nv_nvdla_flopram_fifo_param
  import nv_fifo_pkg::*;
#(
  parameter int WIDTH = 50,
  parameter int DEPTH = 4
) (
  input  logic                          clk,
  input  logic                          reset_,
  nv_nvdla_flopram_fifo_param_if.slave  bus,
  input  logic [31:0]                   pwrbus_ram_pd
);

  localparam int AW = ptr_w(DEPTH);
  localparam int CW = cnt_w(DEPTH);

  `NV_FIFO_POW2_CHECK(DEPTH)

  logic [AW-1:0] wr_ptr;
  logic [AW-1:0] rd_ptr;
  logic [CW-1:0] wr_count;
  logic [CW-1:0] rd_count;
  logic          push;
  logic          pop;
  logic          commit;
  logic          unused_pwrbus;

  assign unused_pwrbus = ^pwrbus_ram_pd;

  // Ready depends only on registered state, so no ready->valid loop is formed.
  assign bus.wr_ready = (wr_count != CW'(DEPTH));
  assign bus.rd_req   = (rd_count != '0);
  assign bus.wr_count = wr_count;
  assign push         = bus.wr_req && bus.wr_ready;
  assign pop          = bus.rd_req && bus.rd_ready;

  always_ff @(posedge clk or negedge reset_) begin
    if (!reset_) begin
      wr_ptr   <= '0;
      rd_ptr   <= '0;
      wr_count <= '0;
      rd_count <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + AW'(1);
      if (pop)  rd_ptr <= rd_ptr + AW'(1);
      wr_count <= wr_count + CW'(push)   - CW'(pop);
      rd_count <= rd_count + CW'(commit) - CW'(pop);
    end
  end

  nv_nvdla_flopram_rwa #(
    .WIDTH (WIDTH),
    .DEPTH (DEPTH),
    .AW    (AW)
  ) u_ram (
    .clk       (clk),
    .reset_    (reset_),
    .we        (push),
    .wa        (wr_ptr),
    .di        (bus.wr_data),
    .ra        (rd_ptr),
    .dout      (bus.rd_data),
    .stage_vld (commit)
  );

  a_no_push_full : assert property (@(posedge clk) disable iff (!reset_)
    push |-> (wr_count != CW'(DEPTH)));
  a_count_max    : assert property (@(posedge clk) disable iff (!reset_)
    wr_count <= CW'(DEPTH));
  a_rd_le_wr     : assert property (@(posedge clk) disable iff (!reset_)
    rd_count <= wr_count);
  a_rd_ge_wr_m1  : assert property (@(posedge clk) disable iff (!reset_)
    ({1'b0, rd_count} + {{CW{1'b0}}, 1'b1}) >= {1'b0, wr_count});

endmodule

`default_nettype wire
